dds_wave_reader: RTL and testbench

//  DDS read engine that drives the 12-bit address port of the waveform ROMs (sine/square/sawtooth,

---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_phase_acc.sv | 46 ++++
 rtl/dds_wave_reader.sv | 193 +++++++++++++++++++
 tb/tb_dds_wave_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform read engine: default widths,
// waveform select codes and the update-handshake FSM encoding.
package dds_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 14;
  localparam int ROM_LAT_DEF = 1;

  localparam logic [1:0] WAVE_SINE = 2'd0;
  localparam logic [1:0] WAVE_SQR  = 2'd1;
  localparam logic [1:0] WAVE_SAWT = 2'd2;
  localparam logic [1:0] WAVE_OFF  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with wrap detection and ROM address generation
// (top ADDR_W accumulator bits plus phase offset, modulo 2^ADDR_W).
module dds_phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [ACC_W-1:0]  fword_i,
  input  logic [ADDR_W-1:0] pword_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              wrap_o,
  output logic              wrap_q_o,
  output logic              acc_zero_o
);

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic              carry;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wrap_q;

  assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, fword_i};
  assign addr_d         = acc_q[ACC_W-1 -: ADDR_W] + pword_i;

  assign wrap_o     = en_i & carry;
  assign wrap_q_o   = wrap_q;
  assign acc_zero_o = (acc_q == '0);
  assign rom_addr_o = addr_q;

  // wrap_q marks that the current acc value is the first of a new period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else if (en_i) begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      wrap_q <= carry;
    end
  end

endmodule

// File: rtl/dds_wave_reader.sv
// DDS read engine: phase-continuous config update FSM, ROM address stage,
// sideband delay matching the ROM latency, and registered waveform mux.
module dds_wave_reader
  import dds_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [ADDR_W-1:0] cfg_pword,
  input  logic [1:0]        cfg_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q_sine,
  input  logic [DATA_W-1:0] rom_q_sqr,
  input  logic [DATA_W-1:0] rom_q_sawt,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              cycle_start
);

  function automatic logic [DATA_W-1:0] wave_mux(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] w);
    case (sel)
      WAVE_SINE: return s;
      WAVE_SQR:  return q;
      WAVE_SAWT: return w;
      default:   return '0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  act_fw_q, act_fw_d, shd_fw_q, shd_fw_d;
  logic [ADDR_W-1:0] act_pw_q, act_pw_d, shd_pw_q, shd_pw_d;
  logic [1:0]        act_sel_q, act_sel_d, shd_sel_q, shd_sel_d;
  logic              accept;
  logic              wrap;
  logic              wrap_q;
  logic              acc_zero;

  assign cfg_ready = (state_q != ST_PEND);
  assign accept    = cfg_valid & cfg_ready;

  dds_phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_phase_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .fword_i    (act_fw_q),
    .pword_i    (act_pw_q),
    .rom_addr_o (rom_addr),
    .wrap_o     (wrap),
    .wrap_q_o   (wrap_q),
    .acc_zero_o (acc_zero)
  );

  always_comb begin
    state_d   = state_q;
    act_fw_d  = act_fw_q;
    act_pw_d  = act_pw_q;
    act_sel_d = act_sel_q;
    shd_fw_d  = shd_fw_q;
    shd_pw_d  = shd_pw_q;
    shd_sel_d = shd_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          act_fw_d  = cfg_fword;
          act_pw_d  = cfg_pword;
          act_sel_d = cfg_sel;
        end
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          if (accept) begin
            act_fw_d  = cfg_fword;
            act_pw_d  = cfg_pword;
            act_sel_d = cfg_sel;
          end
        end else if (accept) begin
          // a wrap in this same cycle is deliberately not used: shadow waits for the next one
          shd_fw_d  = cfg_fword;
          shd_pw_d  = cfg_pword;
          shd_sel_d = cfg_sel;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en || wrap) begin
          act_fw_d  = shd_fw_q;
          act_pw_d  = shd_pw_q;
          act_sel_d = shd_sel_q;
          state_d   = en ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      act_fw_q  <= '0;
      act_pw_q  <= '0;
      act_sel_q <= WAVE_SINE;
      shd_fw_q  <= '0;
      shd_pw_q  <= '0;
      shd_sel_q <= WAVE_SINE;
    end else begin
      state_q   <= state_d;
      act_fw_q  <= act_fw_d;
      act_pw_q  <= act_pw_d;
      act_sel_q <= act_sel_d;
      shd_fw_q  <= shd_fw_d;
      shd_pw_q  <= shd_pw_d;
      shd_sel_q <= shd_sel_d;
    end
  end

  // Stage 0: sideband registered alongside rom_addr
  logic       vld_p0_q;
  logic [1:0] sel_p0_q;
  logic       start_p0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q   <= 1'b0;
      sel_p0_q   <= WAVE_SINE;
      start_p0_q <= 1'b0;
    end else begin
      vld_p0_q   <= en;
      sel_p0_q   <= act_sel_q;
      start_p0_q <= en & (wrap_q | ((state_q == ST_IDLE) & acc_zero));
    end
  end

  // Stage 1: sideband delayed by the ROM latency so it lines up with rom_q_*
  logic [ROM_LAT-1:0] vld_p1_q;
  logic [ROM_LAT-1:0] start_p1_q;
  logic [1:0]         sel_p1_q [ROM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= '0;
      start_p1_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) sel_p1_q[i] <= WAVE_SINE;
    end else begin
      vld_p1_q[0]   <= vld_p0_q;
      start_p1_q[0] <= start_p0_q;
      sel_p1_q[0]   <= sel_p0_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_p1_q[i]   <= vld_p1_q[i-1];
        start_p1_q[i] <= start_p1_q[i-1];
        sel_p1_q[i]   <= sel_p1_q[i-1];
      end
    end
  end

  // Stage 2: registered output mux; dout holds once the pipeline drains
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              cycle_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      dout_valid_q  <= vld_p1_q[ROM_LAT-1];
      cycle_start_q <= vld_p1_q[ROM_LAT-1] & start_p1_q[ROM_LAT-1];
      if (vld_p1_q[ROM_LAT-1])
        dout_q <= wave_mux(sel_p1_q[ROM_LAT-1], rom_q_sine, rom_q_sqr, rom_q_sawt);
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_dds_wave_reader.sv
// Scoreboard bench for dds_wave_reader: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever dout_valid is high.
module tb_dds_wave_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_fword = '0;
  logic [11:0] cfg_pword = '0;
  logic [1:0]  cfg_sel = '0;
  logic [11:0] rom_addr;
  logic [13:0] rom_q_sine, rom_q_sqr, rom_q_sawt;
  logic [13:0] dout;
  logic        dout_valid;
  logic        cycle_start;

  always #5 clk = ~clk;

  dds_wave_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_fword   (cfg_fword),
    .cfg_pword   (cfg_pword),
    .cfg_sel     (cfg_sel),
    .rom_addr    (rom_addr),
    .rom_q_sine  (rom_q_sine),
    .rom_q_sqr   (rom_q_sqr),
    .rom_q_sawt  (rom_q_sawt),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .cycle_start (cycle_start)
  );

  // ROM contents: distinct per waveform so a wrong select is visible
  function automatic logic [13:0] rom_sine(input logic [11:0] a);
    logic [13:0] t;
    t = {2'b00, a};
    return t * 14'd5 + 14'd7;
  endfunction
  function automatic logic [13:0] rom_sqr(input logic [11:0] a);
    return a[11] ? 14'h0400 : 14'h3BFF;
  endfunction
  function automatic logic [13:0] rom_sawt(input logic [11:0] a);
    return {a, 2'b00};
  endfunction

  logic [11:0] ra_q = '0;
  always @(posedge clk) ra_q <= rom_addr;
  assign rom_q_sine = rom_sine(ra_q);
  assign rom_q_sqr  = rom_sqr(ra_q);
  assign rom_q_sawt = rom_sawt(ra_q);

  typedef struct packed {
    logic [13:0] d;
    logic        cs;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_tot++;
          $display("FAIL sample: unexpected dout=%0h with empty scoreboard", dout);
        end else begin
          e = sbq.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("cycle_start", 32'(cycle_start), 32'(e.cs));
        end
      end else if (rst_n === 1'b1) begin
        check("cycle_start_idle", 32'(cycle_start), 32'd0);
      end
    end
  end

  // Expected-behaviour state, phase kept in ROM-address units (fwords are multiples of 2^20)
  int          ph;
  logic [31:0] m_fw, s_fw;
  logic [11:0] m_pw, s_pw;
  logic [1:0]  m_sel, s_sel;
  bit          m_pend, m_idle, m_start;

  task automatic model_reset();
    ph = 0; m_fw = '0; m_pw = '0; m_sel = '0; s_fw = '0; s_pw = '0; s_sel = '0;
    m_pend = 0; m_idle = 1; m_start = 0;
  endtask

  // One clock: called at a negedge, returns at the following negedge
  task automatic tick(input bit e_i, input bit ofr, input logic [31:0] fw,
                      input logic [11:0] pw, input logic [1:0] sl);
    bit          acc_ok, wrap;
    int          nxt;
    logic [11:0] a;
    exp_t        x;
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    en = e_i; cfg_valid = ofr; cfg_fword = fw; cfg_pword = pw; cfg_sel = sl;
    acc_ok = ofr && !m_pend;
    wrap = 0;
    if (e_i) begin
      a    = 12'(ph + int'(m_pw));
      x.d  = (m_sel == 2'd3) ? 14'd0 : (m_sel == 2'd0) ? rom_sine(a) :
             (m_sel == 2'd1) ? rom_sqr(a) : rom_sawt(a);
      x.cs = m_start || (m_idle && ph == 0);
      sbq.push_back(x);
      nxt     = ph + int'(m_fw >> 20);
      wrap    = (nxt >= 4096);
      ph      = nxt % 4096;
      m_start = wrap;
    end
    if (m_pend) begin
      if (!e_i || wrap) begin
        m_fw = s_fw; m_pw = s_pw; m_sel = s_sel; m_pend = 0;
      end
    end else if (acc_ok) begin
      if (m_idle || !e_i) begin
        m_fw = fw; m_pw = pw; m_sel = sl;
      end else begin
        s_fw = fw; s_pw = pw; s_sel = sl; m_pend = 1;
      end
    end
    m_idle = !e_i;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b1, 1'b0, '0, '0, '0);
  endtask
  task automatic stop(input int n);
    repeat (n) tick(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    n_tot++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_cycle_start", 32'(cycle_start), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    // Sawtooth at one address per sample, a full period plus a little
    tick(1'b0, 1'b1, 32'h0010_0000, 12'h000, 2'd2);
    stop(1);
    run(4106);

    // Doubled step offered mid-period, takes effect on the wrap sample
    tick(1'b1, 1'b1, 32'h0020_0000, 12'h000, 2'd2);
    check("ready_low_pending", 32'(cfg_ready), 32'd0);
    run(4085 + 20);

    // Offer exactly on a wrap cycle: applied one full period later; fword=0 then freezes
    run(2027);
    tick(1'b1, 1'b1, 32'h0000_0000, 12'h123, 2'd0);
    run(2048 + 30);

    // Pending cfg applied by en falling; then phase offset 0xFFF from acc=0
    tick(1'b1, 1'b1, 32'h0010_0000, 12'hFFF, 2'd2);
    stop(5);
    check("drain_valid", 32'(dout_valid), 32'd0);
    check("drain_hold", 32'(dout), 32'(rom_sine(12'h123)));
    check("ready_after_apply", 32'(cfg_ready), 32'd1);
    run(20);
    stop(4);
    check("toggle_valid_low", 32'(dout_valid), 32'd0);
    check("toggle_hold", 32'(dout), 32'(rom_sawt(12'h012)));
    run(10);
    stop(4);

    // sel=3 outputs zero while valid keeps pulsing
    tick(1'b0, 1'b1, 32'h0010_0000, 12'h000, 2'd3);
    run(10);
    stop(4);

    // Asynchronous reset while running with a config pending
    run(1);
    tick(1'b1, 1'b1, 32'h0030_0000, 12'h005, 2'd1);
    run(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_dout_valid", 32'(dout_valid), 32'd0);
    check("arst_cycle_start", 32'(cycle_start), 32'd0);
    check("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    sbq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    check("latency_early", 32'(dout_valid), 32'd0);
    run(1);
    check("latency_3", 32'(dout_valid), 32'd1);
    run(8);
    stop(5);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
